bmw_io_slave: RTL

Responder end of the 16-bit init/load/fetch/ack host protocol used to drive the BMW-256 core. Sits inside the core top between the external 16-bit port and the compression datapath. Packs 32 loaded 16-bit words into one 512-bit message block for the core and serves the 256-bit digest back as 16 fetched words. Generates the `ack` that the host waits on for every load and fetch.

---
 rtl/bmw_pkg.sv | 15 +
 rtl/bmw_io_slave_if.sv | 33 +++
 rtl/bmw_io_unpack.sv | 26 ++
 rtl/bmw_io_slave.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bmw_pkg.sv
// Shared constants and state encoding for the BMW-256 host I/O responder.
package bmw_pkg;

  localparam int unsigned BMW_IOW     = 16;
  localparam int unsigned BMW_BLKW    = 512;
  localparam int unsigned BMW_DIGW    = 256;
  localparam int unsigned BMW_LDWORDS = BMW_BLKW / BMW_IOW;
  localparam int unsigned BMW_FTWORDS = BMW_DIGW / BMW_IOW;

  typedef enum logic [0:0] {
    BMW_IO_FILL = 1'b0,
    BMW_IO_SEND = 1'b1
  } bmw_io_state_e;

endpackage

// File: rtl/bmw_io_slave_if.sv
// Host word port plus core block/digest port of the BMW-256 I/O responder.
interface bmw_io_slave_if
  import bmw_pkg::*;
#(
  parameter int unsigned IOW  = BMW_IOW,
  parameter int unsigned BLKW = BMW_BLKW,
  parameter int unsigned DIGW = BMW_DIGW
);

  logic            init;
  logic            load;
  logic            fetch;
  logic [IOW-1:0]  idata;
  logic            ack;
  logic [IOW-1:0]  odata;
  logic            core_init;
  logic [BLKW-1:0] blk_data;
  logic            blk_valid;
  logic            blk_ready;
  logic            dig_valid;
  logic [DIGW-1:0] dig_data;

  modport slave (
    input  init, load, fetch, idata, blk_ready, dig_valid, dig_data,
    output ack, odata, core_init, blk_data, blk_valid
  );

  modport master (
    output init, load, fetch, idata, blk_ready, dig_valid, dig_data,
    input  ack, odata, core_init, blk_data, blk_valid
  );

endinterface

// File: rtl/bmw_io_unpack.sv
// Digest word selector: picks fetch word i_sel, word 0 being the top slice.
module bmw_io_unpack
  import bmw_pkg::*;
#(
  parameter int unsigned IOW  = BMW_IOW,
  parameter int unsigned DIGW = BMW_DIGW
) (
  input  logic [DIGW-1:0]                 i_dig_data,
  input  logic [$clog2(DIGW/IOW)-1:0]     i_sel,
  output logic [IOW-1:0]                  o_word
);

  localparam int unsigned Words = DIGW / IOW;

  logic [IOW-1:0] w_words [Words];

  for (genvar g = 0; g < Words; g++) begin : g_word
    assign w_words[g] = i_dig_data[DIGW-1-g*IOW -: IOW];
  end

  // Plain mux on the fetch counter.
  always_comb begin
    o_word = w_words[i_sel];
  end

endmodule

// File: rtl/bmw_io_slave.sv
// Responder end of the 16-bit init/load/fetch/ack host protocol for BMW-256.
// Packs 32 loaded words into a 512-bit block and serves the digest as 16 words.
// Optional macro BMW_IO_ERR_EN adds the err output (protocol violation pulse).
module bmw_io_slave
  import bmw_pkg::*;
#(
  parameter int unsigned IOW  = BMW_IOW,
  parameter int unsigned BLKW = BMW_BLKW,
  parameter int unsigned DIGW = BMW_DIGW
) (
  input  logic          clk,
  input  logic          rst,
  bmw_io_slave_if.slave bus
`ifdef BMW_IO_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int unsigned LdWords = BLKW / IOW;
  localparam int unsigned FtWords = DIGW / IOW;
  localparam int unsigned WcntW   = $clog2(LdWords);
  localparam int unsigned FcntW   = $clog2(FtWords);

  bmw_io_state_e    r_state, w_state_nxt;
  logic [WcntW-1:0] r_wcnt, w_wcnt_nxt;
  logic [FcntW-1:0] r_fcnt, w_fcnt_nxt;
  logic             r_ack, w_ack_nxt;
  logic [IOW-1:0]   r_odata, w_odata_nxt;
  logic [BLKW-1:0]  r_blk, w_blk_nxt;
  logic             r_blk_valid, w_blk_valid_nxt;
  logic             r_core_init, w_core_init_nxt;
  logic             w_load_cap;
  logic             w_fetch_cap;
  logic [IOW-1:0]   w_dig_word;

  bmw_io_unpack #(
    .IOW  (IOW),
    .DIGW (DIGW)
  ) u_unpack (
    .i_dig_data (bus.dig_data),
    .i_sel      (r_fcnt),
    .o_word     (w_dig_word)
  );

  // Next state: init beats load, load beats fetch; ack high blocks any capture.
  always_comb begin
    w_state_nxt     = r_state;
    w_wcnt_nxt      = r_wcnt;
    w_fcnt_nxt      = r_fcnt;
    w_ack_nxt       = 1'b0;
    w_odata_nxt     = r_odata;
    w_blk_nxt       = r_blk;
    w_blk_valid_nxt = r_blk_valid;
    w_core_init_nxt = 1'b0;
    w_load_cap      = (r_state == BMW_IO_FILL) && bus.load && !r_ack;
    w_fetch_cap     = (r_state == BMW_IO_FILL) && bus.fetch && !bus.load && !r_ack &&
                      bus.dig_valid;

    if (bus.init) begin
      // Aborts any pending block.
      w_core_init_nxt = 1'b1;
      w_wcnt_nxt      = '0;
      w_fcnt_nxt      = '0;
      w_state_nxt     = BMW_IO_FILL;
      w_blk_valid_nxt = 1'b0;
    end else if (w_load_cap) begin
      for (int unsigned i = 0; i < LdWords; i++) begin
        if (r_wcnt == WcntW'(i)) begin
          w_blk_nxt[(LdWords-1-i)*IOW +: IOW] = bus.idata;
        end
      end
      w_wcnt_nxt = r_wcnt + 1'b1;
      w_fcnt_nxt = '0;
      w_ack_nxt  = 1'b1;
      if (r_wcnt == WcntW'(LdWords - 1)) begin
        w_state_nxt     = BMW_IO_SEND;
        w_blk_valid_nxt = 1'b1;
      end
    end else if (w_fetch_cap) begin
      w_odata_nxt = w_dig_word;
      w_fcnt_nxt  = r_fcnt + 1'b1;
      w_ack_nxt   = 1'b1;
    end else if ((r_state == BMW_IO_SEND) && r_blk_valid && bus.blk_ready) begin
      w_state_nxt     = BMW_IO_FILL;
      w_blk_valid_nxt = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BMW_IO_FILL;
      r_wcnt      <= '0;
      r_fcnt      <= '0;
      r_ack       <= 1'b0;
      r_odata     <= '0;
      r_blk       <= '0;
      r_blk_valid <= 1'b0;
      r_core_init <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_ack       <= w_ack_nxt;
      r_odata     <= w_odata_nxt;
      r_blk       <= w_blk_nxt;
      r_blk_valid <= w_blk_valid_nxt;
      r_core_init <= w_core_init_nxt;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.odata     = r_odata;
  assign bus.blk_data  = r_blk;
  assign bus.blk_valid = r_blk_valid;
  assign bus.core_init = r_core_init;

`ifdef BMW_IO_ERR_EN
  logic r_err, w_err_nxt;

  // Misuse detection only; it never changes what gets captured.
  always_comb begin
    w_err_nxt = (bus.load && bus.fetch) ||
                (bus.init && (r_state == BMW_IO_SEND)) ||
                (bus.fetch && (r_wcnt != '0));
  end

  // One-cycle error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`endif

endmodule
